// File: rtl/mpc_mac_pipe.sv
// ---------------------------------------------------------------------------
// mpc_mac_pipe
// Pipelined multiply-accumulate for the MPC datapath. A signed operand is
// multiplied by a signed or unsigned operand. The product is either returned
// on its own or added into a running accumulator. The result then goes
// through a rounding right shift and is reduced to P_W bits.
//
// Optional feature macro: MPC_MAC_SAT_EN
//   defined   -> results outside the P_W signed range are clamped, and o_ovf
//                flags the clamped result.
//   undefined -> results wrap to their low P_W bits, and o_ovf is tied to 0.
//
// Parameters: A_W, B_W, B_SIGNED, P_W, ACC_W, SHIFT, STAGES (total latency)
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_ce         clock enable; when low, every register holds
//   i_in_valid   the sample on i_a/i_b is valid
//   i_acc_en     add this product to the running sum
//   i_acc_clr    with i_acc_en, start a new sum from this product
//   i_a          signed multiplicand
//   i_b          multiplier (signed when B_SIGNED=1)
//   o_out_valid  o_p/o_ovf carry a result
//   o_p          signed result
//   o_ovf        the result was clamped
// ---------------------------------------------------------------------------
module mpc_mac_pipe #(
    parameter int A_W      = 21,
    parameter int B_W      = 8,
    parameter int B_SIGNED = 0,
    parameter int P_W      = 30,
    parameter int ACC_W    = 48,
    parameter int SHIFT    = 0,
    parameter int STAGES   = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_ce,
    input  logic           i_in_valid,
    input  logic           i_acc_en,
    input  logic           i_acc_clr,
    input  logic [A_W-1:0] i_a,
    input  logic [B_W-1:0] i_b,
    output logic           o_out_valid,
    output logic [P_W-1:0] o_p,
    output logic           o_ovf
);

    localparam int PROD_W = A_W + B_W + 1;
    // Index 0 of the output delay line is the S3 result register.
    localparam int DLY    = STAGES - 2;
    // Rounding constant: half an LSB of the shifted result (0 when SHIFT=0).
    localparam logic signed [ACC_W:0] ROUND = ((ACC_W+1)'(1) << SHIFT) >>> 1;

    generate
        if (STAGES < 3) begin : g_badStages
            $error("mpc_mac_pipe: STAGES must be at least 3");
        end
        if (ACC_W < PROD_W) begin : g_badAccW
            $error("mpc_mac_pipe: ACC_W must be at least A_W+B_W+1");
        end
        if ((SHIFT < 0) || (SHIFT > ACC_W - P_W)) begin : g_badShift
            $error("mpc_mac_pipe: SHIFT out of range 0..ACC_W-P_W");
        end
    endgenerate

    logic signed [A_W-1:0]    r_aS1;
    logic        [B_W-1:0]    r_bS1;
    logic                     r_vS1, r_enS1, r_clrS1;
    logic signed [PROD_W-1:0] r_prodS2;
    logic                     r_vS2, r_enS2, r_clrS2;
    logic signed [ACC_W-1:0]  r_acc;
    logic        [P_W-1:0]    r_pPipe [DLY];
    logic        [DLY-1:0]    r_ovfPipe;
    logic        [DLY-1:0]    r_vPipe;

    logic signed [B_W:0]      w_bExt;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prodExt;
    logic signed [ACC_W-1:0]  w_accNext;
    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W:0]    w_r;
    logic        [P_W-1:0]    w_pS3;
    logic                     w_ovfS3;

    // S1: capture operands and sample controls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_aS1    <= '0;
            r_bS1    <= '0;
            r_vS1    <= 1'b0;
            r_enS1   <= 1'b0;
            r_clrS1  <= 1'b0;
        end else if (i_ce) begin
            r_aS1    <= i_a;
            r_bS1    <= i_b;
            r_vS1    <= i_in_valid;
            r_enS1   <= i_acc_en;
            r_clrS1  <= i_acc_clr;
        end
    end

    // Unsigned b gets one zero bit so that the signed multiply treats it as
    // non-negative.
    assign w_bExt = (B_SIGNED != 0) ? {r_bS1[B_W-1], r_bS1} : {1'b0, r_bS1};
    assign w_prod = PROD_W'(r_aS1) * PROD_W'(w_bExt);

    // S2: full-width product register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prodS2 <= '0;
            r_vS2    <= 1'b0;
            r_enS2   <= 1'b0;
            r_clrS2  <= 1'b0;
        end else if (i_ce) begin
            r_prodS2 <= w_prod;
            r_vS2    <= r_vS1;
            r_enS2   <= r_enS1;
            r_clrS2  <= r_clrS1;
        end
    end

    assign w_prodExt = ACC_W'(r_prodS2);
    assign w_accNext = (r_enS2 && !r_clrS2) ? (r_acc + w_prodExt) : w_prodExt;
    // One guard bit stops the rounding add from wrapping before the shift.
    assign w_sum     = {w_accNext[ACC_W-1], w_accNext} + ROUND;
    assign w_r       = w_sum >>> SHIFT;

`ifdef MPC_MAC_SAT_EN
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-P_W+2){1'b0}}, {(P_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W-P_W+2){1'b1}}, {(P_W-1){1'b0}}};

    // Clamp the output to the P_W signed range. The accumulator itself is
    // left unclamped.
    always_comb begin
        w_pS3   = w_r[P_W-1:0];
        w_ovfS3 = 1'b0;
        if (w_r > MAXV) begin
            w_pS3   = MAXV[P_W-1:0];
            w_ovfS3 = 1'b1;
        end else if (w_r < MINV) begin
            w_pS3   = MINV[P_W-1:0];
            w_ovfS3 = 1'b1;
        end
    end
`else
    logic w_unusedHigh;
    assign w_pS3        = w_r[P_W-1:0];
    assign w_ovfS3      = 1'b0;
    assign w_unusedHigh = ^w_r[ACC_W:P_W];
`endif

    // S3: the accumulator feeds back on itself every cycle. Only valid
    // samples update it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_ce && r_vS2) begin
            r_acc <= w_accNext;
        end
    end

    // The S3 result register followed by plain delay stages up to STAGES.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DLY; i++) begin
                r_pPipe[i] <= '0;
            end
            r_ovfPipe <= '0;
            r_vPipe   <= '0;
        end else if (i_ce) begin
            r_pPipe[0]   <= w_pS3;
            r_ovfPipe[0] <= w_ovfS3 & r_vS2;
            r_vPipe[0]   <= r_vS2;
            for (int i = 1; i < DLY; i++) begin
                r_pPipe[i]   <= r_pPipe[i-1];
                r_ovfPipe[i] <= r_ovfPipe[i-1];
                r_vPipe[i]   <= r_vPipe[i-1];
            end
        end
    end

    assign o_p         = r_pPipe[DLY-1];
    assign o_ovf       = r_ovfPipe[DLY-1];
    assign o_out_valid = r_vPipe[DLY-1];

endmodule

// File: tb/tb_mpc_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_mpc_mac_pipe
// Self-checking bench for mpc_mac_pipe. It drives two instances from the same
// inputs: one with default parameters and one with SHIFT=4.
//
// An arithmetic model predicts each result from the sample stream:
//   - the product,
//   - the sum, wrapped at 48 bits,
//   - the rounding shift,
//   - the reduction to 30 bits.
// The model keys each prediction to the enabled clock edge that captured the
// sample. It follows MPC_MAC_SAT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_mpc_mac_pipe;

    localparam int A_W = 21;
    localparam int B_W = 8;
    localparam int P_W = 30;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic           ce       = 1'b1;
    logic           inValid  = 1'b0;
    logic           accEn    = 1'b0;
    logic           accClr   = 1'b0;
    logic [A_W-1:0] a        = '0;
    logic [B_W-1:0] b        = '0;
    logic           outValid, ovf, outValidSh, ovfSh;
    logic [P_W-1:0] p, pSh;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mpc_mac_pipe dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_in_valid(inValid),
        .i_acc_en(accEn), .i_acc_clr(accClr), .i_a(a), .i_b(b),
        .o_out_valid(outValid), .o_p(p), .o_ovf(ovf)
    );

    mpc_mac_pipe #(.SHIFT(4)) dutShift (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_in_valid(inValid),
        .i_acc_en(accEn), .i_acc_clr(accClr), .i_a(a), .i_b(b),
        .o_out_valid(outValidSh), .o_p(pSh), .o_ovf(ovfSh)
    );

    // Model state
    longint modelAcc;
    longint modelProd;
    longint pv;
    bit     ov;
    int     edgeCount;
    longint expP[int];
    bit     expOvf[int];
    longint expPSh[int];
    bit     expOvfSh[int];
    // Results consumed by the downstream side (out_valid while ce is high)
    longint logP[$];
    bit     logOvf[$];
    longint logPSh[$];
    int     cycles;

    task automatic checkOutput(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Round half up, then reduce to P_W bits by clamping or wrapping.
    function automatic void reduceResult(input longint acc, input int sh,
                                         output longint pOut, output bit ovOut);
        longint r, maxV, minV;
        r    = (acc + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0))) >>> sh;
        maxV = (longint'(1) <<< (P_W - 1)) - 1;
        minV = -(longint'(1) <<< (P_W - 1));
`ifdef MPC_MAC_SAT_EN
        if (r > maxV) begin
            pOut = maxV; ovOut = 1'b1;
        end else if (r < minV) begin
            pOut = minV; ovOut = 1'b1;
        end else begin
            pOut = r; ovOut = 1'b0;
        end
`else
        pOut  = (r <<< (64 - P_W)) >>> (64 - P_W);
        ovOut = 1'b0;
`endif
    endfunction

    // Model: on every enabled edge, work out the result the sample must give.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            modelAcc  = 0;
            edgeCount = 0;
            expP.delete();
            expOvf.delete();
            expPSh.delete();
            expOvfSh.delete();
        end else if (ce) begin
            edgeCount++;
            if (inValid) begin
                modelProd = longint'($signed(a)) * longint'(b);
                if (accEn && !accClr) modelAcc = modelAcc + modelProd;
                else modelAcc = modelProd;
                modelAcc = (modelAcc <<< 16) >>> 16;
                reduceResult(modelAcc, 0, pv, ov);
                expP[edgeCount]   = pv;
                expOvf[edgeCount] = ov;
                reduceResult(modelAcc, 4, pv, ov);
                expPSh[edgeCount]   = pv;
                expOvfSh[edgeCount] = ov;
            end
        end
    end

    // Compare: check both instances against the model on every falling edge.
    // A sample captured at enabled edge n is due after edge n+3.
    initial forever begin
        int  key;
        bit  hasExp;
        @(negedge clk);
        if (rst_n) begin
            key    = edgeCount - 3;
            hasExp = expP.exists(key);
            checkOutput("outValid", longint'(outValid), longint'(hasExp));
            if (hasExp && outValid) begin
                checkOutput("p", longint'($signed(p)), expP[key]);
                checkOutput("ovf", longint'(ovf), longint'(expOvf[key]));
            end
            checkOutput("outValidSh", longint'(outValidSh), longint'(hasExp));
            if (hasExp && outValidSh) begin
                checkOutput("pSh", longint'($signed(pSh)), expPSh[key]);
                checkOutput("ovfSh", longint'(ovfSh), longint'(expOvfSh[key]));
            end
            if (outValid && ce) begin
                logP.push_back(longint'($signed(p)));
                logOvf.push_back(ovf);
            end
            if (outValidSh && ce) logPSh.push_back(longint'($signed(pSh)));
        end
    end

    // Drive one sample, then return 2 time units after the edge that took it.
    task automatic applyStimulus(input bit v, input bit en, input bit clr,
                                 input int av, input int bv);
        inValid = v;
        accEn   = en;
        accClr  = clr;
        a       = av[A_W-1:0];
        b       = bv[B_W-1:0];
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        inValid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clearLogs();
        logP.delete();
        logOvf.delete();
        logPSh.delete();
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("resetValid", longint'(outValid), 0);
        checkOutput("resetP", longint'($signed(p)), 0);
        checkOutput("resetOvf", longint'(ovf), 0);
        #10 rst_n = 1'b1;

        // Single multiply: measure latency, then take a corner product.
        clearLogs();
        applyStimulus(1, 0, 0, -3, 200);
        inValid = 1'b0;
        cycles = 1;
        repeat (10) begin
            @(negedge clk);
            if (outValid) break;
            cycles++;
        end
        checkOutput("latency", cycles, 4);
        applyStimulus(1, 0, 0, -1048576, 255);
        idle(8);
        checkOutput("singleCount", logP.size(), 2);
        checkOutput("single0", logP[0], -600);
        checkOutput("single0Ovf", longint'(logOvf[0]), 0);
        checkOutput("single1", logP[1], -267386880);

        // Accumulate, then restart the sum.
        clearLogs();
        applyStimulus(1, 1, 1, 1000, 100);
        applyStimulus(1, 1, 0, 1000, 100);
        applyStimulus(1, 1, 0, 1000, 100);
        applyStimulus(1, 1, 1, 7, 1);
        idle(8);
        checkOutput("accCount", logP.size(), 4);
        checkOutput("acc0", logP[0], 100000);
        checkOutput("acc1", logP[1], 200000);
        checkOutput("acc2", logP[2], 300000);
        checkOutput("acc3", logP[3], 7);

        // Overflow
        clearLogs();
        applyStimulus(1, 1, 1, -1048576, 255);
        applyStimulus(1, 1, 0, -1048576, 255);
        applyStimulus(1, 1, 0, -1048576, 255);
        idle(8);
        checkOutput("ovfCount", logP.size(), 3);
        checkOutput("ovf0", logP[0], -267386880);
        checkOutput("ovf1", logP[1], -534773760);
        checkOutput("ovf1Flag", longint'(logOvf[1]), 0);
`ifdef MPC_MAC_SAT_EN
        checkOutput("ovf2", logP[2], -536870912);
        checkOutput("ovf2Flag", longint'(logOvf[2]), 1);
`else
        checkOutput("ovf2", logP[2], 271581184);
        checkOutput("ovf2Flag", longint'(logOvf[2]), 0);
`endif

        // Rounding on the SHIFT=4 instance
        clearLogs();
        applyStimulus(1, 0, 0, 40, 1);
        applyStimulus(1, 0, 0, -40, 1);
        applyStimulus(1, 0, 0, 24, 1);
        idle(8);
        checkOutput("roundCount", logPSh.size(), 3);
        checkOutput("round0", logPSh[0], 3);
        checkOutput("round1", logPSh[1], -2);
        checkOutput("round2", logPSh[2], 2);

        // Stall with results already on the output
        clearLogs();
        for (int i = 1; i <= 6; i++) begin
            if (i == 5) begin
                inValid = 1'b1; accEn = 1'b1; accClr = 1'b0;
                a = A_W'(5); b = B_W'(3);
                ce = 1'b0;
                repeat (3) @(posedge clk);
                #2;
                ce = 1'b1;
            end
            applyStimulus(1, 1, (i == 1), i, 3);
        end
        idle(8);
        checkOutput("stallCount", logP.size(), 6);
        checkOutput("stall0", logP[0], 3);
        checkOutput("stall1", logP[1], 9);
        checkOutput("stall2", logP[2], 18);
        checkOutput("stall3", logP[3], 30);
        checkOutput("stall4", logP[4], 45);
        checkOutput("stall5", logP[5], 63);

        // Reset with samples in flight
        clearLogs();
        applyStimulus(1, 1, 1, 11, 2);
        applyStimulus(1, 1, 0, 12, 2);
        applyStimulus(1, 1, 0, 13, 2);
        applyStimulus(1, 1, 0, 14, 2);
        checkOutput("preResetValid", longint'(outValid), 1);
        #1 rst_n = 1'b0;
        inValid = 1'b0;
        #1;
        checkOutput("midResetValid", longint'(outValid), 0);
        checkOutput("midResetP", longint'($signed(p)), 0);
        #4 rst_n = 1'b1;
        applyStimulus(1, 1, 0, 5, 2);
        idle(8);
        checkOutput("postResetCount", logP.size(), 1);
        checkOutput("postReset", logP[0], 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpc_mac_pipe.md
# mpc_mac_pipe

Parametrised pipelined multiply-accumulate unit for the MPC datapath: signed `a` times signed or unsigned `b`, with an optional running accumulation, rounding right-shift and range reduction to `P_W` bits. It is the general successor to the fixed-width per-operand DSP48 multipliers and is used wherever the solver needs dot products or gain-scaled terms. It is pipelined with a valid flag and a global clock enable, and it maps to one DSP48 slice plus fabric registers.

## Interface
- `A_W`, 21: width of `a`; always signed.
- `B_W`, 8: width of `b`.
- `B_SIGNED`, 0: 1 means `b` is two's complement; 0 means `b` is unsigned and is zero-extended by one bit.
- `P_W`, 30: output width; signed.
- `ACC_W`, 48: accumulator width. Must be at least `A_W+B_W+1`.
- `SHIFT`, 0: arithmetic right shift applied before range reduction, in the range 0..ACC_W-P_W.
- `STAGES`, 4: total latency in cycles, minimum 3.
- `clk` in 1: clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ce` in 1: clock enable. When low, every register holds.
- `in_valid` in 1: the sample on `a`/`b` is valid.
- `acc_en` in 1: add this sample's product to the accumulator.
- `acc_clr` in 1: with `acc_en`, start a new sum from this sample.
- `a` in A_W: signed multiplicand.
- `b` in B_W: multiplier.
- `out_valid` out 1: `p`/`ovf` carry a result.
- `p` out P_W: signed result.
- `ovf` out 1: this result was clamped.

## Operation
- S1 (input stage): register `a`, `b`, `in_valid`, `acc_en` and `acc_clr`.
- S2 (product stage): register the full product, `prod = a_s1 * b_ext`.
  - `b_ext` is `b` sign-extended when `B_SIGNED=1`, otherwise `{1'b0,b}`.
  - Product width is `A_W+B_W+1`, sign-extended to `ACC_W`.
- S3 (accumulate stage), on a valid sample:
  - `acc_en=0`: `acc_next = prod` (single multiply).
  - `acc_en=1, acc_clr=1`: `acc_next = prod`.
  - `acc_en=1, acc_clr=0`: `acc_next = acc + prod`, wrapping modulo 2^ACC_W.
  - `acc <= acc_next`.
  - Result: `r = (acc_next + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT`, i.e. round half toward +inf.
  - `r` is range-reduced to `P_W` bits (see Configuration) and registered together with `ovf` and valid.
- Invalid samples leave `acc` unchanged and produce `out_valid=0`. The `p` register still updates with don't-care data.
- S4..S`STAGES`: plain delay registers for `p`, `ovf` and `out_valid`.
- `ce=0` freezes the whole pipe, including `acc` and the valid bits. No sample is lost or duplicated.

## Timing
- Latency is `STAGES` enabled cycles from `in_valid` at an edge to `out_valid` at the output. Throughput is 1 sample per cycle; there is no back-pressure.
- Reset (`rst=0`) takes effect immediately and asynchronously. All pipeline registers clear: `p=0`, `ovf=0`, `out_valid=0`, `acc=0`. Samples in flight are discarded.
- After reset is released, the first accumulate sample with `acc_clr=0` sums onto 0.
- Back-to-back accumulate samples are legal every cycle. S3 uses its own registered `acc` with single-cycle feedback.
- An `acc_clr=1` sample immediately after a running sum returns that sum on the preceding sample. The new sum starts cleanly.
- Parameter violations (`STAGES<3`, `ACC_W` too small) stop elaboration through a generate-time error.

## Configuration
- `MPC_MAC_SAT_EN` defined:
  - If `r` exceeds `2^(P_W-1)-1`, `p` is clamped to that value.
  - If `r` is below `-2^(P_W-1)`, `p` is clamped to that value.
  - `ovf=1` for exactly that result.
  - The accumulator itself is not clamped.
- `MPC_MAC_SAT_EN` undefined:
  - `p` = low `P_W` bits of `r` (wrap).
  - `ovf` is tied to 0.

## Test plan
All cases use default parameters unless stated.
- **Single multiply:** `a=-3, b=200, acc_en=0` -> `p=-600`, `out_valid` 4 cycles later, `ovf=0`.
  - Corner case: `a=-1048576, b=255` -> `p=-267386880`.
- **Accumulate:** 3 consecutive samples `a=1000, b=100`, the first with `acc_clr=1`, all with `acc_en=1` -> `p=100000, 200000, 300000` on consecutive cycles.
  - A 4th sample with `acc_clr=1`, `a=7, b=1` -> `p=7`.
- **Overflow:** 3 accumulating samples of `a=-1048576, b=255`.
  - With `MPC_MAC_SAT_EN`: `p=-267386880, -534773760, -536870912`, with `ovf=1` on the third result only.
  - Without the macro: the third result is `p=271581184`, `ovf=0`.
- **Rounding:** `SHIFT=4`, `a=40, b=1` -> `p=3`; `a=-40, b=1` -> `p=-2`; `a=24, b=1` -> `p=2`.
- **Stall:** a stream of 6 accumulate samples with `ce` low for 3 cycles mid-stream -> same 6 results, each valid one delayed by 3 cycles, with no duplicates.
- **Reset mid-flight:** pull `rst` low with 3 samples in flight -> `out_valid=0` and `p=0` the same cycle.
  - After release, one accumulate sample `a=5, b=2, acc_clr=0` -> `p=10`.
